program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
// AXI-lite write master that drives the program_ctrl register interface of the MIPS computer.
// Pulls a word stream (instructions then data) from an upstream buffer and loads it:
//   - asserts programming mode
//   - writes the instruction words
//   - writes the data words, each with its address
//   - releases programming mode
// Sits between the host-side loader FIFO and the program_ctrl AXI-lite slave.
// Only the write channels are used; the read channels are tied off outside this block.
// PARAMETERS
// BASE_ADDR  32'h0  AXI-lite base address of program_ctrl; register offsets below are added to it
// CNT_W      16     width of the instruction and data word counters
// PORTS
// clk        in   1      clock
// rst_n      in   1      synchronous, active-low reset
// start      in   1      1-cycle pulse; begins a load when idle
// ins_cnt    in   CNT_W  number of instruction words; sampled on accepted start
// data_cnt   in   CNT_W  number of data words; sampled on accepted start
// data_base  in   32     byte address of first data word; sampled on accepted start
// s_word     in   32     stream word (instructions first, then data)
// s_valid    in   1      stream word valid
// s_ready    out  1      stream word accepted when s_valid&s_ready
// m_awaddr   out  32     AXI-lite write address
// m_awvalid  out  1      AXI-lite write address valid
// m_awready  in   1      AXI-lite write address ready
// m_wdata    out  32     AXI-lite write data
// m_wstrb    out  4      AXI-lite write strobe; always 4'hF
// m_wvalid   out  1      AXI-lite write data valid
// m_wready   in   1      AXI-lite write data ready
// m_bresp    in   2      AXI-lite write response
// m_bvalid   in   1      AXI-lite write response valid
// m_bready   out  1      AXI-lite write response ready
// busy       out  1      high from accepted start until done
// done       out  1      1-cycle pulse when the load sequence ends
// err        out  1      sticky; set on any bresp!=2'b00; cleared on the next accepted start
// BEHAVIOUR
// Register map: CTRL=+0x0 (bit0=program mode), INS_DATA=+0x4 (slave auto-increments instruction address),
//   DATA_ADDR=+0x8, DATA_DATA=+0xC.
// Reset: all outputs 0 except m_wstrb=4'hF; FSM=IDLE; counters 0.
// Reset mid-operation: valids drop in the same cycle and no stream word is consumed.
// States: IDLE, CTRL_ON, INS, DADDR, DDATA, CTRL_OFF, DONE.
//   IDLE: on start, latch inputs, clear err, set busy, go to CTRL_ON. start while busy is ignored.
//   CTRL_ON:  write CTRL=1. Then go to INS if ins_cnt!=0; else DADDR if data_cnt!=0; else CTRL_OFF.
//   INS:      per word, write INS_DATA=word. Repeat ins_cnt times, then go to DADDR or CTRL_OFF.
//   DADDR:    write DATA_ADDR = data_base + 4*k (k = data word index, mod 2^32). Then go to DDATA.
//   DDATA:    write DATA_DATA=word. Back to DADDR until data_cnt words are done, then CTRL_OFF.
//   CTRL_OFF: write CTRL=0. Then go to DONE.
//   DONE:     done=1 for 1 cycle, busy=0, go to IDLE.
// Write transaction, one outstanding:
//   - awvalid and wvalid rise in the same cycle.
//   - Each valid drops the cycle after its own ready is sampled high; AW and W may complete in either order or together.
//   - A valid never drops before its ready is seen, and addr/data stay stable while valid.
//   - After both complete, bready=1 until bvalid; the next write issues the cycle after the B handshake at the earliest.
// Stream: in INS and DDATA, s_ready=1 only while no write is in flight and the word is not yet latched.
//   - The word latches on s_valid&s_ready; awvalid/wvalid rise the next cycle.
//   - s_valid low stalls the load indefinitely.
// Latency: accepted start -> awvalid of the CTRL write is 1 cycle.
// Error: bresp!=OKAY on any write except CTRL_OFF sets err and jumps to CTRL_OFF (release is always attempted).
//   - No further stream words are consumed.
//   - An error on the CTRL_OFF write sets err and still goes to DONE.
// Counters: CNT_W bits; a count of 0 skips that phase entirely, and all-ones is legal.
// TESTING
// T1: ins_cnt=2, data_cnt=0, words A,B, always-ready slave
//   -> writes CTRL=1, INS=A, INS=B, CTRL=0; done pulses once; err=0.
// T2: ins_cnt=0, data_cnt=2, data_base=0x100, words C,D
//   -> writes DADDR=0x100, DDATA=C, DADDR=0x104, DDATA=D, framed by CTRL writes.
// T3: awready delayed 3 cycles, wready immediate (and the reverse)
//   -> valids held until their own ready; exactly one transaction per register.
// T4: bresp=2'b10 on the second INS write of ins_cnt=4
//   -> err=1; next write is CTRL=0; only 2 words consumed; done pulses.
// T5: s_valid low for 10 cycles mid-INS -> no AXI activity; load resumes after s_valid returns.
// T6: rst_n low while awvalid=1 -> next cycle all valids/busy=0; a new start performs a full clean load.

Source files
------------

// File: rtl/program_loader.sv
// AXI-lite write master that loads a program into program_ctrl: enters programming mode,
// streams instruction words, writes each data word with its address, then leaves programming mode.
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CNT_W-1:0] ins_cnt_i,
    input  logic [CNT_W-1:0] data_cnt_i,
    input  logic [31:0]      data_base_i,
    input  logic [31:0]      s_word_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [31:0]      m_awaddr_o,
    output logic             m_awvalid_o,
    input  logic             m_awready_i,
    output logic [31:0]      m_wdata_o,
    output logic [3:0]       m_wstrb_o,
    output logic             m_wvalid_o,
    input  logic             m_wready_i,
    input  logic [1:0]       m_bresp_i,
    input  logic             m_bvalid_i,
    output logic             m_bready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam logic [31:0] CtrlAddr  = BASE_ADDR + 32'h0;
    localparam logic [31:0] InsAddr   = BASE_ADDR + 32'h4;
    localparam logic [31:0] DaddrAddr = BASE_ADDR + 32'h8;
    localparam logic [31:0] DdataAddr = BASE_ADDR + 32'hC;

    typedef enum logic [2:0] {
        StIdle, StCtrlOn, StIns, StDaddr, StDdata, StCtrlOff, StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] ins_rem_q, ins_rem_d;
    logic [CNT_W-1:0] data_rem_q, data_rem_d;
    logic [31:0]      data_addr_q, data_addr_d;
    logic [31:0]      awaddr_q, awaddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             awvalid_q, awvalid_d;
    logic             wvalid_q, wvalid_d;
    logic             bready_q, bready_d;
    logic             err_q, err_d;

    logic   in_flight;
    logic   s_fire;
    logic   b_fire;
    logic   b_err;
    logic   issue;
    state_e after_ins;

    assign in_flight = awvalid_q | wvalid_q | bready_q;
    // Reset gates the handshake outputs combinationally so nothing is offered or consumed in reset.
    assign s_ready_o = rst_n & ~in_flight & ((state_q == StIns) | (state_q == StDdata));
    assign s_fire    = s_ready_o & s_valid_i;
    assign b_fire    = bready_q & m_bvalid_i;
    assign b_err     = b_fire & (m_bresp_i != 2'b00);
    assign after_ins = (data_rem_q != '0) ? StDaddr : StCtrlOff;

    always_comb begin
        state_d     = state_q;
        ins_rem_d   = ins_rem_q;
        data_rem_d  = data_rem_q;
        data_addr_d = data_addr_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        err_d       = err_q;
        issue       = 1'b0;

        if (awvalid_q && m_awready_i) awvalid_d = 1'b0;
        if (wvalid_q && m_wready_i)   wvalid_d  = 1'b0;
        if ((awvalid_q || wvalid_q) && !awvalid_d && !wvalid_d) bready_d = 1'b1;
        if (b_fire) bready_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    ins_rem_d   = ins_cnt_i;
                    data_rem_d  = data_cnt_i;
                    data_addr_d = data_base_i;
                    err_d       = 1'b0;
                    state_d     = StCtrlOn;
                    issue       = 1'b1;
                end
            end
            StCtrlOn: begin
                if (b_fire) begin
                    issue = 1'b1;
                    if (b_err) begin
                        err_d   = 1'b1;
                        state_d = StCtrlOff;
                    end else if (ins_rem_q != '0) begin
                        state_d = StIns;
                        issue   = 1'b0;
                    end else begin
                        state_d = after_ins;
                    end
                end
            end
            StIns: begin
                if (b_fire) begin
                    ins_rem_d = ins_rem_q - CNT_W'(1);
                    if (b_err) begin
                        err_d   = 1'b1;
                        state_d = StCtrlOff;
                        issue   = 1'b1;
                    end else if (ins_rem_q == CNT_W'(1)) begin
                        state_d = after_ins;
                        issue   = 1'b1;
                    end
                end
            end
            StDaddr: begin
                if (b_fire) begin
                    if (b_err) begin
                        err_d   = 1'b1;
                        state_d = StCtrlOff;
                        issue   = 1'b1;
                    end else begin
                        state_d = StDdata;
                    end
                end
            end
            StDdata: begin
                if (b_fire) begin
                    data_rem_d  = data_rem_q - CNT_W'(1);
                    data_addr_d = data_addr_q + 32'd4;
                    issue       = 1'b1;
                    if (b_err) begin
                        err_d   = 1'b1;
                        state_d = StCtrlOff;
                    end else if (data_rem_q == CNT_W'(1)) begin
                        state_d = StCtrlOff;
                    end else begin
                        state_d = StDaddr;
                    end
                end
            end
            StCtrlOff: begin
                if (b_fire) begin
                    if (b_err) err_d = 1'b1;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Register writes that carry no stream word are launched on the state transition itself.
        if (issue) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            if (state_d == StDaddr) begin
                awaddr_d = DaddrAddr;
                wdata_d  = data_addr_d;
            end else begin
                awaddr_d = CtrlAddr;
                wdata_d  = {31'b0, state_d == StCtrlOn};
            end
        end

        if (s_fire) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = (state_q == StIns) ? InsAddr : DdataAddr;
            wdata_d   = s_word_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ins_rem_q   <= '0;
            data_rem_q  <= '0;
            data_addr_q <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ins_rem_q   <= ins_rem_d;
            data_rem_q  <= data_rem_d;
            data_addr_q <= data_addr_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            err_q       <= err_d;
        end
    end

    assign m_awaddr_o  = awaddr_q;
    assign m_wdata_o   = wdata_q;
    assign m_wstrb_o   = 4'hF;
    assign m_awvalid_o = awvalid_q & rst_n;
    assign m_wvalid_o  = wvalid_q & rst_n;
    assign m_bready_o  = bready_q & rst_n;
    assign busy_o      = (state_q != StIdle) && (state_q != StDone);
    assign done_o      = (state_q == StDone);
    assign err_o       = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: AXI-lite slave model with programmable ready delays and error
// injection, a word source, and a scoreboard of expected register writes.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] ins_cnt, data_cnt;
    logic [31:0] data_base;
    logic [31:0] s_word;
    logic        s_valid;
    logic        s_ready_o;
    logic [31:0] m_awaddr_o, m_wdata_o;
    logic        m_awvalid_o, m_awready, m_wvalid_o, m_wready;
    logic [3:0]  m_wstrb_o;
    logic [1:0]  m_bresp;
    logic        m_bvalid, m_bready_o;
    logic        busy_o, done_o, err_o;

    always #5 clk = ~clk;

    program_loader #(.BASE_ADDR(32'h0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .ins_cnt_i(ins_cnt), .data_cnt_i(data_cnt),
        .data_base_i(data_base), .s_word_i(s_word), .s_valid_i(s_valid), .s_ready_o(s_ready_o),
        .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready),
        .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wvalid_o(m_wvalid_o),
        .m_wready_i(m_wready), .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid),
        .m_bready_o(m_bready_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] src_q[$];

    task automatic sb_push(input logic [31:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    task automatic add_word(input logic [31:0] a, input logic [31:0] w);
        src_q.push_back(w);
        sb_push(a, w);
    endtask

    // Slave model
    int          aw_delay = 0, w_delay = 0, aw_cnt = 0, w_cnt = 0;
    int          txn = 0, err_at = -1;
    logic        aw_got, w_got;
    logic [31:0] cap_addr, cap_data;

    assign m_awready = !aw_got && (aw_cnt >= aw_delay);
    assign m_wready  = !w_got && (w_cnt >= w_delay);

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
            m_bvalid <= 1'b0; m_bresp <= 2'b00;
            cap_addr <= '0; cap_data <= '0;
        end else begin
            if (m_awvalid_o && !aw_got) begin
                if (m_awready) begin
                    aw_got <= 1'b1; cap_addr <= m_awaddr_o; aw_cnt <= 0;
                end else aw_cnt <= aw_cnt + 1;
            end
            if (m_wvalid_o && !w_got) begin
                if (m_wready) begin
                    w_got <= 1'b1; cap_data <= m_wdata_o; w_cnt <= 0;
                end else w_cnt <= w_cnt + 1;
            end
            if (aw_got && w_got && !m_bvalid) begin
                m_bvalid <= 1'b1;
                m_bresp  <= (txn == err_at) ? 2'b10 : 2'b00;
            end
            if (m_bvalid && m_bready_o) begin
                m_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; txn <= txn + 1;
            end
        end
    end

    // Scoreboard, done counter and valid/stability monitor
    int          done_cnt = 0, viol = 0;
    logic        pv_aw = 1'b0, pr_aw = 1'b0, pv_w = 1'b0, pr_w = 1'b0;
    logic [31:0] pa = '0, pd = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (done_o) done_cnt++;
            if (rst_n && m_bvalid && m_bready_o) begin
                if (exp_addr_q.size() == 0) begin
                    check_eq("extra_write_addr", cap_addr, 32'hDEAD_DEAD);
                end else begin
                    check_eq("wr_addr", cap_addr, exp_addr_q.pop_front());
                    check_eq("wr_data", cap_data, exp_data_q.pop_front());
                end
            end
            if (rst_n) begin
                if (pv_aw && !pr_aw && (!m_awvalid_o || m_awaddr_o != pa)) viol++;
                if (pv_w && !pr_w && (!m_wvalid_o || m_wdata_o != pd)) viol++;
            end
            pv_aw = m_awvalid_o; pr_aw = m_awready; pa = m_awaddr_o;
            pv_w  = m_wvalid_o;  pr_w  = m_wready;  pd = m_wdata_o;
        end
    end

    // Word source
    logic src_en = 1'b1;
    logic fire   = 1'b0;
    int   consumed = 0;

    initial begin
        s_valid = 1'b0;
        s_word  = '0;
        forever begin
            @(negedge clk);
            if (fire && src_q.size() > 0) begin
                void'(src_q.pop_front());
                consumed++;
            end
            s_valid = src_en && (src_q.size() > 0);
            s_word  = s_valid ? src_q[0] : 32'h0;
            fire    = s_valid && s_ready_o && rst_n;
        end
    end

    task automatic do_start(input int ins, input int dat, input logic [31:0] base);
        @(negedge clk);
        ins_cnt = 16'(ins); data_cnt = 16'(dat); data_base = base; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_awvalid", 32'(m_awvalid_o), 32'd1);
        check_eq("start_busy", 32'(busy_o), 32'd1);
        check_eq("start_awaddr", m_awaddr_o, 32'h0);
        check_eq("start_err_clr", 32'(err_o), 32'd0);
    endtask

    task automatic finish_load(input logic exp_err);
        int d0 = done_cnt;
        int t  = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_eq("done_seen", 32'(done_cnt != d0), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("done_once", 32'(done_cnt - d0), 32'd1);
        check_eq("busy_idle", 32'(busy_o), 32'd0);
        check_eq("err", 32'(err_o), 32'(exp_err));
        check_eq("sb_left", 32'(exp_addr_q.size()), 32'd0);
    endtask

    initial begin
        int t;
        int act;
        rst_n = 1'b0; start = 1'b0; ins_cnt = '0; data_cnt = '0; data_base = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_awvalid", 32'(m_awvalid_o), 32'd0);
        check_eq("rst_wvalid", 32'(m_wvalid_o), 32'd0);
        check_eq("rst_bready", 32'(m_bready_o), 32'd0);
        check_eq("rst_sready", 32'(s_ready_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_err", 32'(err_o), 32'd0);
        check_eq("rst_wstrb", 32'(m_wstrb_o), 32'hF);
        check_eq("rst_awaddr", m_awaddr_o, 32'h0);

        // T1: two instruction words
        sb_push(32'h0, 32'd1);
        add_word(32'h4, 32'hAAAA_0001);
        add_word(32'h4, 32'hBBBB_0002);
        sb_push(32'h0, 32'd0);
        do_start(2, 0, 32'h0);
        check_eq("wstrb_busy", 32'(m_wstrb_o), 32'hF);
        finish_load(1'b0);
        check_eq("t1_consumed", 32'(consumed), 32'd2);

        // T2: two data words
        sb_push(32'h0, 32'd1);
        sb_push(32'h8, 32'h100); add_word(32'hC, 32'hCCCC_0003);
        sb_push(32'h8, 32'h104); add_word(32'hC, 32'hDDDD_0004);
        sb_push(32'h0, 32'd0);
        do_start(0, 2, 32'h100);
        finish_load(1'b0);

        // Both counts zero: just the two CTRL writes
        sb_push(32'h0, 32'd1);
        sb_push(32'h0, 32'd0);
        do_start(0, 0, 32'h0);
        finish_load(1'b0);

        // Data address wraps modulo 2^32
        sb_push(32'h0, 32'd1);
        sb_push(32'h8, 32'hFFFF_FFFC); add_word(32'hC, 32'h1234_5678);
        sb_push(32'h8, 32'h0000_0000); add_word(32'hC, 32'h9ABC_DEF0);
        sb_push(32'h0, 32'd0);
        do_start(0, 2, 32'hFFFF_FFFC);
        finish_load(1'b0);

        // T3: skewed ready timing, both orders
        for (int k = 0; k < 2; k++) begin
            aw_delay = (k == 0) ? 3 : 0;
            w_delay  = (k == 0) ? 0 : 3;
            sb_push(32'h0, 32'd1);
            add_word(32'h4, 32'h5100_0000 + 32'(k));
            sb_push(32'h8, 32'h40); add_word(32'hC, 32'h5200_0000 + 32'(k));
            sb_push(32'h0, 32'd0);
            do_start(1, 1, 32'h40);
            finish_load(1'b0);
        end
        aw_delay = 0; w_delay = 0;

        // T4: error response on the second instruction write
        consumed = 0;
        err_at = txn + 2;
        sb_push(32'h0, 32'd1);
        sb_push(32'h4, 32'h4000_0000); sb_push(32'h4, 32'h4000_0001);
        for (int i = 0; i < 4; i++) src_q.push_back(32'h4000_0000 + 32'(i));
        sb_push(32'h0, 32'd0);
        do_start(4, 0, 32'h0);
        finish_load(1'b1);
        check_eq("t4_consumed", 32'(consumed), 32'd2);
        err_at = -1;
        src_q.delete();

        // T5: source stalls mid-load
        consumed = 0;
        sb_push(32'h0, 32'd1);
        for (int i = 0; i < 3; i++) add_word(32'h4, 32'h5500_0000 + 32'(i));
        sb_push(32'h0, 32'd0);
        do_start(3, 0, 32'h0);
        t = 0;
        while (consumed < 1 && t < 200) begin @(negedge clk); t++; end
        src_en = 1'b0;
        t = 0;
        while (!s_ready_o && t < 200) begin @(negedge clk); t++; end
        check_eq("t5_waiting", 32'(s_ready_o), 32'd1);
        act = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_awvalid_o || m_wvalid_o) act++;
        end
        check_eq("t5_idle_bus", 32'(act), 32'd0);
        check_eq("t5_consumed", 32'(consumed), 32'd1);
        src_en = 1'b1;
        finish_load(1'b0);

        // T6: reset while the CTRL write is being offered
        sb_push(32'h0, 32'd1);
        add_word(32'h4, 32'h6600_0000);
        add_word(32'h4, 32'h6600_0001);
        do_start(2, 0, 32'h0);
        rst_n = 1'b0;
        #1;
        check_eq("t6_awvalid_now", 32'(m_awvalid_o), 32'd0);
        check_eq("t6_wvalid_now", 32'(m_wvalid_o), 32'd0);
        @(negedge clk);
        check_eq("t6_busy", 32'(busy_o), 32'd0);
        check_eq("t6_bready", 32'(m_bready_o), 32'd0);
        rst_n = 1'b1;
        exp_addr_q.delete(); exp_data_q.delete(); src_q.delete();
        @(negedge clk);
        check_eq("t6_awvalid_after", 32'(m_awvalid_o), 32'd0);
        aw_delay = 1; w_delay = 2;
        sb_push(32'h0, 32'd1);
        add_word(32'h4, 32'h7700_0000);
        add_word(32'h4, 32'h7700_0001);
        sb_push(32'h8, 32'h200); add_word(32'hC, 32'h7700_0002);
        sb_push(32'h0, 32'd0);
        do_start(2, 1, 32'h200);
        finish_load(1'b0);

        check_eq("valid_protocol", 32'(viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
